// File: rtl/rr_arb3_code_pkg.sv
// Shared types for the 3-way round-robin arbiter.
// Holds the FSM state enum, the idle code and the requester-to-code map.
package rr_arb3_code_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;

    // Requester i is encoded as i+1 so that 00 stays "no owner".
    function automatic logic [1:0] req2code(input logic [1:0] i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Ports: req[2:0], last[1:0] in; found, idx[1:0] out.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);

    // Search order is last+1, last+2, last (mod 3).
    always_comb begin
        found = |req;
        idx   = 2'd0;
        unique case (last)
            2'd0: begin
                if (req[1])      idx = 2'd1;
                else if (req[2]) idx = 2'd2;
                else             idx = 2'd0;
            end
            2'd1: begin
                if (req[2])      idx = 2'd2;
                else if (req[0]) idx = 2'd0;
                else             idx = 2'd1;
            end
            default: begin
                if (req[0])      idx = 2'd0;
                else if (req[1]) idx = 2'd1;
                else             idx = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/rr_arb3_code.sv
// Three-requester round-robin arbiter with bounded hold and a 00 gap.
// Ports: clk, rst, req[2:0], done in; code[1:0], busy, tmo out (registered).
module rr_arb3_code
    import rr_arb3_code_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [1:0] code,
    output logic       busy,
    output logic       tmo
);

    state_t           state, state_n;
    logic [1:0]       last, last_n;
    logic [1:0]       owner, owner_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       code_n;
    logic             busy_n;
    logic             tmo_n;
    logic             found;
    logic [1:0]       idx;
    logic             own_req;
    logic             at_max;

    rr_pick3 u_pick (
        .req   (req),
        .last  (last),
        .found (found),
        .idx   (idx)
    );

    assign own_req = req[owner];
    assign at_max  = (cnt == CNT_W'(HOLD_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 2'd2;
            owner <= 2'd0;
            cnt   <= '0;
            code  <= CODE_NONE;
            busy  <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            code  <= code_n;
            busy  <= busy_n;
            tmo   <= tmo_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        owner_n = owner;
        cnt_n   = cnt;
        code_n  = CODE_NONE;
        busy_n  = 1'b0;
        tmo_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    owner_n = idx;
                    code_n  = req2code(idx);
                    busy_n  = 1'b1;
                    cnt_n   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (done || !own_req || at_max) begin
                    state_n = GAP;
                    last_n  = owner;
                    cnt_n   = '0;
                    // done and own request win over the hold limit
                    tmo_n   = !done && own_req;
                end else begin
                    code_n  = code;
                    busy_n  = 1'b1;
                    cnt_n   = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
